// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
// These are the default bubble PC, the control-bit positions and the stage occupancy states.
package pipe_pkg;

  localparam logic [31:0] PC_BUBBLE_DEFAULT = 32'hFFFF_FFFF;

  localparam int CTRL_MEMREAD   = 0;
  localparam int CTRL_MEMWRITE  = 1;
  localparam int CTRL_WBDATA    = 2;
  localparam int CTRL_REGWRITE  = 3;
  localparam int CTRL_DATAWRITE = 4;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_SKID = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// It holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, flush, bubble insertion and a stall counter.
// Defining PIPE_STAGE_SKID_EN adds one skid entry, which makes in_ready a pure register output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              CTRL_W    = 5,
  parameter int              DATA_W    = 32,
  parameter int              N_DATA    = 2,
  parameter int              REG_W     = 4,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] PC_BUBBLE = {PC_W{1'b1}},
  parameter int              CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [DATA_W*N_DATA-1:0] in_data,
  input  logic [REG_W-1:0]         in_dest,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [DATA_W*N_DATA-1:0] out_data,
  output logic [REG_W-1:0]         out_dest,
  output logic [PC_W-1:0]          out_pc,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int PW = CTRL_W + DATA_W*N_DATA + REG_W + PC_W;

  pipe_state_e     state_q, state_d;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   in_payload;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PC_W-1:0] main_pc;
  logic            accept, drain, load_main;

  assign in_payload = {in_ctrl, in_data, in_dest, in_pc};
  assign out_valid  = (state_q != EMPTY);
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [PW-1:0] skid_q;
  logic          load_skid, main_from_skid;

  assign in_ready = (state_q != FULL_SKID);
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            load_main = 1'b1;
          end
        end
        FULL: begin
          if (drain) begin
            if (accept) load_main = 1'b1;
            else        state_d   = EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (accept) begin
            state_d   = FULL_SKID;
            load_skid = 1'b1;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL_SKID: begin
          if (drain) begin
            main_from_skid = 1'b1;
            if (accept) load_skid = 1'b1;
            else        state_d   = FULL;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: the main payload is reset because out_data/out_dest must read 0 after reset.
  // The skid payload is not reset, because its validity lives entirely in state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= {{(PW-PC_W){1'b0}}, PC_BUBBLE};
    end else begin
      if (load_main) main_q <= in_payload;
`ifdef PIPE_STAGE_SKID_EN
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_payload;
`endif
    end
  end

  assign {main_ctrl, out_data, out_dest, main_pc} = main_q;

  // Bubbles must never carry side-effecting control or a real PC.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_pc   = out_valid ? main_pc   : PC_BUBBLE;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (CNT_W=4 so saturation is reachable).
// It models the stage as a FIFO of accepted instructions with capacity 1, or 2 with PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [4:0]  ctrl;
    logic [63:0] data;
    logic [3:0]  dest;
    logic [31:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_dest = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_ctrl;
  logic [63:0] out_data;
  logic [3:0]  out_dest;
  logic [31:0] out_pc;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit seen_300 = 1'b0;

  pipe_stage_reg #(
    .CTRL_W (5), .DATA_W (32), .N_DATA (2), .REG_W (4), .PC_W (32),
    .PC_BUBBLE (PC_BUBBLE_DEFAULT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_ctrl (in_ctrl), .in_data (in_data), .in_dest (in_dest), .in_pc (in_pc),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_ctrl (out_ctrl), .out_data (out_data), .out_dest (out_dest), .out_pc (out_pc),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model and scoreboard: sampled 1 time unit before each rising edge.
  initial begin
    item_t mq[$];
    item_t it;
    int    cnt = 0;
    bit    known = 1'b0;
    bit    exp_rdy, acc, drn;
    forever begin
      @(negedge clk);
      #4;
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = (mq.size() < 2);
`else
      exp_rdy = (mq.size() == 0) || out_ready;
`endif
      if (known) begin
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
          check("out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
          check("out_data", out_data, mq[0].data);
          check("out_dest", 64'(out_dest), 64'(mq[0].dest));
          check("out_pc", 64'(out_pc), 64'(mq[0].pc));
        end else begin
          check("bubble_ctrl", 64'(out_ctrl), 64'(0));
          check("bubble_pc", 64'(out_pc), 64'(32'hFFFF_FFFF));
        end
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("stall_cnt", 64'(stall_cnt), 64'(cnt));
      end
      if (out_valid && out_pc == 32'h300) seen_300 = 1'b1;

      if (reset) begin
        mq.delete();
        cnt   = 0;
        known = 1'b1;
      end else begin
        acc = in_valid && exp_rdy;
        drn = (mq.size() != 0) && out_ready;
        if (mq.size() != 0 && !out_ready && cnt < CNT_MAX) cnt++;
        if (flush) begin
          mq.delete();
        end else begin
          if (drn) void'(mq.pop_front());
          if (acc) begin
            it.ctrl = in_ctrl; it.data = in_data; it.dest = in_dest; it.pc = in_pc;
            mq.push_back(it);
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] ctrl,
                      input logic ordy, input logic fl);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = v;
    in_pc     = pc;
    in_ctrl   = ctrl;
    in_data   = {$urandom(), $urandom()};
    in_dest   = 4'($urandom());
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset    = 1'b1;
      in_valid = $urandom_range(0, 1) != 0;
      flush    = 1'b0;
    end
  endtask

  initial begin
    logic [4:0] flush_ctrl;
    flush_ctrl = 5'((1 << CTRL_MEMWRITE) | (1 << CTRL_REGWRITE));

    do_reset(2);

    // Streaming with no gaps.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4*i), 5'($urandom()), 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

    // Back-pressure on a single held instruction.
    do_reset(2);
    step(1'b1, 32'h200, 5'h1F, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    #4 check("backpressure_stall_cnt", 64'(stall_cnt), 64'(3));
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

    // Flush in the same cycle an input is accepted.
    step(1'b1, 32'h300, flush_ctrl, 1'b1, 1'b1);
    repeat (2) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

    // Counter saturation.
    step(1'b1, 32'h500, 5'h3, 1'b0, 1'b0);
    repeat (20) step(1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    #4 check("stall_saturate", 64'(stall_cnt), 64'(4'hF));
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
    // Two instructions held: main + skid, then drained in order.
    step(1'b1, 32'h400, 5'h2, 1'b0, 1'b0);
    step(1'b1, 32'h404, 5'h4, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    #4 check("skid_full_in_ready", 64'(in_ready), 64'(0));
    repeat (3) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
`endif

    // Randomized traffic with a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      step($urandom_range(0, 3) != 0, 32'h8000_0000 | 32'($urandom()), 5'($urandom()),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (3) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    #4 check("flushed_pc_never_seen", 64'(seen_300), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
